mem_bus_bridge: RTL and testbench

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bus_bridge_pkg.sv | 14 +
 rtl/mem_bus_bridge_bus_wdt.sv | 36 +++
 rtl/mem_bus_bridge.sv | 116 +++++++++++
 tb/tb_mem_bus_bridge.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and constants for the MEM-stage bus bridge and its watchdog.
package mem_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } bridge_state_e;

    localparam int unsigned WAIT_MAX_DEFAULT = 15;
    localparam int unsigned WDT_WIDTH        = 8;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;

endpackage

// File: rtl/mem_bus_bridge_bus_wdt.sv
// Bus wait-cycle watchdog: saturating counter that flags the cycle in which
// the WAIT_MAX-th consecutive un-acked request cycle completes.
module bus_wdt
    import mem_bus_bridge_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_timeout
);

    localparam int unsigned CW = WDT_WIDTH + 1;
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

    logic [WDT_WIDTH-1:0] r_count;
    logic [CW-1:0]        w_countNext;

    assign w_countNext = {1'b0, r_count} + CW'(1);

    // Timeout fires in the cycle whose increment would reach WAIT_MAX.
    assign o_timeout = i_count && (w_countNext >= LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count && (w_countNext <= LIMIT)) begin
            r_count <= w_countNext[WDT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridges single MEM-stage load/store requests onto a simple req/ack bus,
// stalling the pipeline until the access completes or times out.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_rdata_o,
    output logic        stall_req_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o
);

    bridge_state_e r_state;
    bridge_state_e w_nextState;
    logic          r_busWe;
    logic [31:0]   r_busAddr;
    logic [31:0]   r_busWdata;
    logic [31:0]   r_rdata;
    logic          r_busErr;
    logic          r_stale;
    logic          w_inReq;
    logic          w_timeout;
    logic          w_stall;

    assign w_inReq = (r_state == ST_REQ);

    bus_wdt #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wdt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_inReq),
        .i_count   (w_inReq && !bus_ack_i),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (mem_ce_i) w_nextState = ST_REQ;
            ST_REQ:  if (bus_ack_i || w_timeout) w_nextState = ST_DONE;
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Ack takes priority over a simultaneous timeout; writes return zero data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busWe    <= 1'b0;
            r_busAddr  <= ZERO_WORD;
            r_busWdata <= ZERO_WORD;
            r_rdata    <= ZERO_WORD;
            r_busErr   <= 1'b0;
            r_stale    <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && mem_ce_i) begin
                r_busWe    <= mem_we_i;
                r_busAddr  <= mem_addr_i;
                r_busWdata <= mem_data_i;
            end
            if (w_inReq && bus_ack_i) begin
                r_rdata <= r_busWe ? ZERO_WORD : bus_rdata_i;
            end else if (w_inReq && w_timeout) begin
                r_rdata <= ZERO_WORD;
            end
            r_busErr <= w_inReq && !bus_ack_i && w_timeout;
            if (r_state == ST_DONE) begin
                r_stale <= 1'b0;
            end else if (w_inReq && !mem_ce_i) begin
                r_stale <= 1'b1;
            end
        end
    end

    // A flushed request must not see DONE as its own completion.
    always_comb begin
        w_stall = 1'b0;
        if (!rst) begin
            w_stall = 1'b0;
        end else if (r_state == ST_DONE) begin
            w_stall = mem_ce_i && r_stale;
        end else begin
            w_stall = mem_ce_i;
        end
    end

    assign stall_req_o = w_stall;
    assign bus_req_o   = w_inReq;
    assign bus_we_o    = r_busWe;
    assign bus_addr_o  = r_busAddr;
    assign bus_wdata_o = r_busWdata;
    assign mem_rdata_o = r_rdata;
    assign bus_err_o   = r_busErr;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: vector table, randomized accesses
// against a transaction-level model, and hand-written flush/reset sequences.
module tb_mem_bus_bridge;

    localparam int WAIT = 4;

    logic        clk;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_rdata_o;
    logic        stall_req_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ackAt;
        logic [31:0] rdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expReqCycles;
    } vec_t;

    vec_t vecs[6];

    mem_bus_bridge #(
        .WAIT_MAX (WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ce_i    (mem_ce_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_rdata_o (mem_rdata_o),
        .stall_req_o (stall_req_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .bus_err_o   (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level expectation: ack at REQ cycle index ackAt, else timeout.
    function automatic void refModel(input logic we, input int ackAt, input logic [31:0] rdata,
                                     output logic [31:0] expRdata, output logic expErr,
                                     output int expCycles);
        expErr    = (ackAt >= WAIT);
        expCycles = expErr ? WAIT : ackAt + 1;
        expRdata  = (we || expErr) ? 32'h0 : rdata;
    endfunction

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int ackAt, input logic [31:0] rdata,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int expReqCycles, input string tag);
        int  reqCycles = 0;
        int  firstIter = -1;
        bit  seenDone  = 0;
        bit  heldOk    = 1;
        nextCycle();
        mem_ce_i   = 1'b1;
        mem_we_i   = we;
        mem_addr_i = addr;
        mem_data_i = wdata;
        bus_ack_i  = 1'b0;
        @(negedge clk);
        checkOutput({tag, "/stall_c0"}, {31'b0, stall_req_o}, 32'd1);
        checkOutput({tag, "/busreq_c0"}, {31'b0, bus_req_o}, 32'd0);
        for (int iter = 0; iter < 40 && !seenDone; iter++) begin
            nextCycle();
            bus_ack_i = 1'b0;
            if (bus_req_o) begin
                if (firstIter < 0) firstIter = iter;
                if (reqCycles == ackAt) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = rdata;
                end else begin
                    bus_rdata_i = $urandom;
                end
                reqCycles++;
                @(negedge clk);
                if (stall_req_o !== 1'b1 || bus_we_o !== we || bus_addr_o !== addr ||
                    bus_wdata_o !== wdata || bus_err_o !== 1'b0)
                    heldOk = 0;
            end else if (reqCycles > 0) begin
                seenDone = 1;
            end
        end
        bus_ack_i = 1'b0;
        @(negedge clk);
        checkOutput({tag, "/completed"}, {31'b0, seenDone}, 32'd1);
        checkOutput({tag, "/first_req_cycle"}, firstIter, 32'd0);
        checkOutput({tag, "/req_cycles"}, reqCycles, expReqCycles);
        checkOutput({tag, "/bus_held"}, {31'b0, heldOk}, 32'd1);
        checkOutput({tag, "/rdata_done"}, mem_rdata_o, expRdata);
        checkOutput({tag, "/err_done"}, {31'b0, bus_err_o}, {31'b0, expErr});
        checkOutput({tag, "/stall_done"}, {31'b0, stall_req_o}, 32'd0);
        nextCycle();
        mem_ce_i = 1'b0;
        @(negedge clk);
        checkOutput({tag, "/err_after"}, {31'b0, bus_err_o}, 32'd0);
        checkOutput({tag, "/rdata_held"}, mem_rdata_o, expRdata);
        checkOutput({tag, "/busreq_after"}, {31'b0, bus_req_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] er;
        logic        ee;
        int          ec;
        logic        rwe;
        int          rAck;
        logic [31:0] rAddr, rWdata, rRdata;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,          2,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678,  0,  32'hAAAA_5555, 32'h0,         1'b0, 1};
        vecs[2] = '{1'b0, 32'h0000_0030, 32'h0,          99, 32'h5555_AAAA, 32'h0,         1'b1, 4};
        vecs[3] = '{1'b0, 32'h0000_0034, 32'h0,          3,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4};
        vecs[4] = '{1'b1, 32'h0000_0038, 32'h0BAD_F00D,  99, 32'h7777_7777, 32'h0,         1'b1, 4};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          0,  32'h0000_0001, 32'h0000_0001, 1'b0, 1};

        rst         = 1'b0;
        mem_ce_i    = 1'b1;
        mem_we_i    = 1'b1;
        mem_addr_i  = 32'h1111_1111;
        mem_data_i  = 32'h2222_2222;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        #2;
        checkOutput("reset/stall", {31'b0, stall_req_o}, 32'd0);
        checkOutput("reset/busreq", {31'b0, bus_req_o}, 32'd0);
        checkOutput("reset/buswe", {31'b0, bus_we_o}, 32'd0);
        checkOutput("reset/busaddr", bus_addr_o, 32'h0);
        checkOutput("reset/buswdata", bus_wdata_o, 32'h0);
        checkOutput("reset/rdata", mem_rdata_o, 32'h0);
        checkOutput("reset/err", {31'b0, bus_err_o}, 32'd0);
        mem_ce_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ackAt, vecs[i].rdata,
                          vecs[i].expRdata, vecs[i].expErr, vecs[i].expReqCycles,
                          $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            rwe    = 1'($urandom_range(0, 1));
            rAck   = int'($urandom_range(0, 6));
            rAddr  = $urandom & 32'hFFFF_FFFC;
            rWdata = $urandom;
            rRdata = $urandom;
            refModel(rwe, rAck, rRdata, er, ee, ec);
            applyStimulus(rwe, rAddr, rWdata, rAck, rRdata, er, ee, ec, $sformatf("rand%0d", i));
        end

        // Flush: ce drops mid-access, a new request appears before the old ack.
        nextCycle();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0040; bus_ack_i = 1'b0;
        nextCycle();
        nextCycle();
        mem_ce_i = 1'b0;
        @(negedge clk);
        checkOutput("flush/busreq_c2", {31'b0, bus_req_o}, 32'd1);
        checkOutput("flush/stall_c2", {31'b0, stall_req_o}, 32'd0);
        nextCycle();
        mem_ce_i = 1'b1; mem_addr_i = 32'h0000_0080;
        @(negedge clk);
        checkOutput("flush/stall_c3", {31'b0, stall_req_o}, 32'd1);
        checkOutput("flush/addr_c3", bus_addr_o, 32'h0000_0040);
        nextCycle();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
        nextCycle();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        @(negedge clk);
        checkOutput("flush/busreq_done", {31'b0, bus_req_o}, 32'd0);
        checkOutput("flush/stall_done", {31'b0, stall_req_o}, 32'd1);
        checkOutput("flush/rdata_done", mem_rdata_o, 32'h1111_2222);
        checkOutput("flush/err_done", {31'b0, bus_err_o}, 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("flush/stall_idle", {31'b0, stall_req_o}, 32'd1);
        checkOutput("flush/busreq_idle", {31'b0, bus_req_o}, 32'd0);
        nextCycle();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3333_4444;
        @(negedge clk);
        checkOutput("flush/busreq_new", {31'b0, bus_req_o}, 32'd1);
        checkOutput("flush/addr_new", bus_addr_o, 32'h0000_0080);
        nextCycle();
        bus_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("flush/stall_new_done", {31'b0, stall_req_o}, 32'd0);
        checkOutput("flush/rdata_new", mem_rdata_o, 32'h3333_4444);
        nextCycle();
        mem_ce_i = 1'b0;

        // Reset in the middle of a write: outputs drop without a clock edge.
        applyStimulus(1'b0, 32'h0000_0044, 32'h0, 1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 2, "pre_reset");
        nextCycle();
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0050; mem_data_i = 32'h9999_8888;
        nextCycle();
        nextCycle();
        checkOutput("midrst/busreq_before", {31'b0, bus_req_o}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst/busreq", {31'b0, bus_req_o}, 32'd0);
        checkOutput("midrst/stall", {31'b0, stall_req_o}, 32'd0);
        checkOutput("midrst/buswe", {31'b0, bus_we_o}, 32'd0);
        checkOutput("midrst/busaddr", bus_addr_o, 32'h0);
        checkOutput("midrst/buswdata", bus_wdata_o, 32'h0);
        checkOutput("midrst/rdata", mem_rdata_o, 32'h0);
        mem_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
